// File: rtl/rr_seq_pkg.sv
// Shared encodings for the result register shift sequencer:
// shift modes and FSM states.
package rr_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROL = 2'b00,
    MODE_LSL = 2'b01,
    MODE_LSR = 2'b10,
    MODE_ASR = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/rr_seq_if.sv
// Command/status bundle between the control unit and the result register.
// The control unit uses the master view; rr_seq uses the slave view.
interface rr_seq_if #(
  parameter int N   = 4,
  parameter int SHW = $clog2(2*N)+1
);
  logic             en;
  logic             clr;
  logic             load;
  logic [2*N-1:0]   data;
  logic             start;
  logic [1:0]       mode;
  logic [SHW-1:0]   amt;
  logic [2*N-1:0]   rr_out;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output en, clr, load, data, start, mode, amt,
    input  rr_out, cout, busy, done
  );

  modport slave (
    input  en, clr, load, data, start, mode, amt,
    output rr_out, cout, busy, done
  );
endinterface

// File: rtl/rr_shift_step.sv
// Combinational one-bit shifter for the four sequencer modes; out_bit is
// the bit that falls off the end (msb for left shifts, lsb for right).
module rr_shift_step
  import rr_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  mode_t        mode,
  output logic [W-1:0] shifted,
  output logic         out_bit
);

  always_comb begin
    shifted = value;
    out_bit = value[W-1];
    case (mode)
      MODE_ROL: shifted = {value[W-2:0], value[W-1]};
      MODE_LSL: shifted = {value[W-2:0], 1'b0};
      MODE_LSR: begin
        shifted = {1'b0, value[W-1:1]};
        out_bit = value[0];
      end
      MODE_ASR: begin
        shifted = {value[W-1], value[W-1:1]};
        out_bit = value[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rr_seq.sv
// 2N-bit result register with parallel load, clear and a start/busy/done
// sequencer that applies a counted run of one-bit shifts.
module rr_seq
  import rr_seq_pkg::*;
#(
  parameter int N   = 4,
  parameter int SHW = $clog2(2*N)+1
) (
  input  logic      clk,
  input  logic      r,
  rr_seq_if.slave   bus
);

  localparam int W = 2*N;
  localparam logic [SHW-1:0] FULL = SHW'(W);

  state_t         state;
  mode_t          mode_q;
  logic [SHW-1:0] cnt;
  logic [W-1:0]   rr_q;
  logic           cout_q;
  logic           busy_q;
  logic           done_q;

  logic [W-1:0]   shifted;
  logic           out_bit;
  logic [SHW-1:0] amt_sat;

  assign amt_sat = (bus.amt > FULL) ? FULL : bus.amt;

  rr_shift_step #(.W(W)) u_step (
    .value   (rr_q),
    .mode    (mode_q),
    .shifted (shifted),
    .out_bit (out_bit)
  );

  // DONE accepts commands like IDLE so a new start can follow with no gap;
  // with en low everything, including a pending done pulse, is frozen.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state  <= IDLE;
      mode_q <= MODE_ROL;
      cnt    <= '0;
      rr_q   <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.en) begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
          if (bus.clr) begin
            rr_q   <= '0;
            cout_q <= 1'b0;
          end else if (bus.load) begin
            rr_q <= bus.data;
          end else if (bus.start) begin
            mode_q <= mode_t'(bus.mode);
            cnt    <= amt_sat;
            if (amt_sat == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= SHIFT;
              busy_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (bus.clr) begin
            rr_q   <= '0;
            cout_q <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            rr_q   <= shifted;
            cout_q <= out_bit;
            cnt    <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.rr_out = rr_q;
  assign bus.cout   = cout_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
